// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared access-size codes, FSM state encoding and a helper
//                returning the byte count of an access size.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Number of bytes touched by an access; the illegal code reports 4 so the
    // range check stays conservative (it is flagged as an error anyway).
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_load_ext.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_load_ext
//  Description : Combinational load formatter. Takes four little-endian raw
//                bytes starting at the access address and produces the
//                sign- or zero-extended 32-bit load result.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    // Extend byte/half loads; words pass straight through.
    always_comb begin
        data_o = raw_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & raw_i[7]}},  raw_i[7:0]};
            SZ_HALF: data_o = {{16{~unsigned_i & raw_i[15]}}, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule : dmem_load_ext
`default_nettype wire

// File: rtl/data_memory_sized.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_sized
//  Description : Byte-addressed little-endian data memory with B/H/W loads and
//                stores, req/ready handshake, configurable wait states,
//                misalignment/range error reporting and a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       rdata_o
);

    localparam int         c_AW       = $clog2(DEPTH_BYTES);
    localparam int         c_AXW      = ADDR_W + 1;
    localparam bit         c_NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] c_CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic               we_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic               done_q;
    logic               err_q;
    logic [31:0]        rdata_q;

    logic [7:0]         mem_q [DEPTH_BYTES];

    logic               w_idle;
    logic               w_accept;
    logic               w_commit;
    logic               w_we;
    logic [1:0]         w_size;
    logic               w_uns;
    logic [ADDR_W-1:0]  w_addr;
    logic [31:0]        w_wdata;
    logic [2:0]         w_nbytes;
    logic [c_AXW-1:0]   w_limit;
    logic               w_range_err;
    logic               w_err;
    logic [c_AW-1:0]    w_idx0;
    logic [c_AW-1:0]    w_idx1;
    logic [c_AW-1:0]    w_idx2;
    logic [c_AW-1:0]    w_idx3;
    logic [31:0]        w_raw;
    logic [31:0]        w_ld;

    assign w_idle   = (state_q == ST_IDLE);
    assign w_accept = req_i & w_idle;

    // With no wait states the commit edge is the accept edge itself, so the
    // live inputs are used while idle and the captured copy afterwards.
    assign w_we    = w_idle ? we_i       : we_q;
    assign w_size  = w_idle ? size_i     : size_q;
    assign w_uns   = w_idle ? unsigned_i : uns_q;
    assign w_addr  = w_idle ? addr_i     : addr_q;
    assign w_wdata = w_idle ? wdata_i    : wdata_q;

    // Commit happens on the edge entering RESP; never while reset is held.
    assign w_commit = rst_i & ((w_accept & c_NO_WAIT) |
                               ((state_q == ST_WAIT) & (cnt_q == 4'd0)));

    // Alignment and range checks on the full address before any truncation.
    assign w_nbytes    = size_bytes(w_size);
    assign w_limit     = c_AXW'(DEPTH_BYTES) - c_AXW'(w_nbytes);
    assign w_range_err = ({1'b0, w_addr} > w_limit);
    assign w_err       = (w_size == SZ_ILL)
                       | ((w_size == SZ_HALF) & w_addr[0])
                       | ((w_size == SZ_WORD) & (|w_addr[1:0]))
                       | w_range_err;

    // Byte lanes; the upper lanes may alias low storage near the top of the
    // array, but they are only consumed when the range check has passed.
    assign w_idx0 = w_addr[c_AW-1:0];
    assign w_idx1 = w_idx0 + c_AW'(1);
    assign w_idx2 = w_idx0 + c_AW'(2);
    assign w_idx3 = w_idx0 + c_AW'(3);
    assign w_raw  = {mem_q[w_idx3], mem_q[w_idx2], mem_q[w_idx1], mem_q[w_idx0]};

    dmem_load_ext u_load_ext (
        .raw_i      (w_raw),
        .size_i     (w_size),
        .unsigned_i (w_uns),
        .data_o     (w_ld)
    );

    // Storage array: written only at a clean store commit, never cleared.
    always_ff @(posedge clk_i) begin
        if (w_commit && w_we && !w_err) begin
            mem_q[w_idx0] <= w_wdata[7:0];
            if (w_size != SZ_BYTE) begin
                mem_q[w_idx1] <= w_wdata[15:8];
            end
            if (w_size == SZ_WORD) begin
                mem_q[w_idx2] <= w_wdata[23:16];
                mem_q[w_idx3] <= w_wdata[31:24];
            end
        end
    end

    // Control FSM with capture registers and registered response outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            done_q <= w_commit;
            err_q  <= w_commit & w_err;
            if (w_commit && !w_we && !w_err) begin
                rdata_q <= w_ld;
            end
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        we_q    <= we_i;
                        size_q  <= size_i;
                        uns_q   <= unsigned_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        if (c_NO_WAIT) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= c_CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready_o = w_idle;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule : data_memory_sized
`default_nettype wire
